hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The module SHALL have one parameter: DIV_CYCLES, default 32, the cycle count from DIV/REM issue to writeback request (legal range 2..63).
REQ-002 The module SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ID_valid  in  1  a real instruction is in ID.
REQ-006 ID_rs1, ID_rs2  in  5 each  ID source registers.
REQ-007 ID_uses_rs1, ID_uses_rs2  in  1 each  ID instruction reads rs1 or rs2.
REQ-008 ID_rd  in  5  ID destination register; ID_regwrite  in  1  ID instruction writes rd.
REQ-009 ID_is_div  in  1  ID instruction is DIV/DIVU/REM/REMU.
REQ-010 EX_rd  in  5  EX destination; EX_regwrite  in  1; EX_memread  in  1  EX holds a load.
REQ-011 div_start  in  1  one-cycle pulse: a DIV/REM in EX issues to the iterative divider, destination EX_rd.
REQ-012 div_wb_ack  in  1  writeback port grants the divider result this cycle.
REQ-013 stall  out  1  hold PC and IF/ID, insert bubble into EX.
REQ-014 div_busy  out  1  divider occupied.
REQ-015 div_wb_req  out  1  divider result ready, writeback port requested.
REQ-016 div_wb_rd  out  5  destination of the pending divider result.
REQ-017 pending_mask  out  32  bit n set = register n awaits divider writeback.
REQ-018 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-019 stall SHALL be combinational, equal to ID_valid AND (load_use OR div_raw OR div_waw OR div_struct).
REQ-020 load_use SHALL be EX_memread & EX_regwrite & EX_rd!=0 & ((ID_uses_rs1 & ID_rs1==EX_rd) | (ID_uses_rs2 & ID_rs2==EX_rd)).
REQ-021 div_raw SHALL be (ID_uses_rs1 & pending_mask[ID_rs1]) | (ID_uses_rs2 & pending_mask[ID_rs2]); index 0 never matches.
REQ-022 div_waw SHALL be ID_regwrite & ID_rd!=0 & pending_mask[ID_rd].
REQ-023 div_struct SHALL be ID_is_div & div_busy & NOT (div_wb_req & div_wb_ack).
REQ-024 The divider state machine SHALL have states IDLE, COUNT, REQ; div_busy = (state != IDLE); div_wb_req = (state == REQ).
REQ-025 IDLE + div_start: SHALL load counter with DIV_CYCLES-1, latch div_wb_rd <= EX_rd, set pending_mask[EX_rd] if EX_rd!=0, go to COUNT.
REQ-026 COUNT: SHALL decrement counter each cycle; when counter==0, SHALL go to REQ next cycle, so div_wb_req rises exactly DIV_CYCLES cycles after the div_start edge.
REQ-027 REQ: SHALL hold div_wb_req and div_wb_rd stable until div_wb_ack; on ack, SHALL clear pending_mask[div_wb_rd] and go to IDLE.
REQ-028 REQ + div_wb_ack + div_start in the same cycle: SHALL clear the old bit, then set the new bit (set wins if same register), reload the counter, and go to COUNT.
REQ-029 div_start in COUNT, or in REQ without ack, SHALL be ignored (no state change) and SHALL set proto_err.
REQ-030 div_wb_ack outside REQ SHALL be ignored and SHALL set proto_err.
REQ-031 pending_mask SHALL never have more than one bit set; bit 0 SHALL always read 0.
REQ-032 The counter SHALL be 6 bits wide and SHALL NOT wrap below zero.

Reset
REQ-033 When rst is high at a clock edge: state <= IDLE, counter <= 0, pending_mask <= 0, div_wb_rd <= 0, proto_err <= 0; div_busy and div_wb_req SHALL read 0 the next cycle.
REQ-034 Reset mid-divide SHALL discard the in-flight result with no div_wb_req.
REQ-035 During reset, stall SHALL still follow REQ-019, using the cleared state.

Verification
REQ-036 Load-use: EX_memread=1, EX_rd=5, ID_rs1=5, ID_uses_rs1=1, ID_valid=1 -> stall=1; with EX_rd=0 -> stall=0.
REQ-037 Divide latency: DIV_CYCLES=32, div_start with EX_rd=7 -> pending_mask=0x80; div_wb_req=1 and div_wb_rd=7 exactly 32 cycles later; ID_rs2=7 reader stalls the whole time.
REQ-038 Held request: no ack for 5 cycles in REQ -> div_wb_req stays 1; ack -> pending_mask=0 and div_busy=0 next cycle.
REQ-039 Back-to-back: ack and div_start (EX_rd=7) together -> pending_mask=0x80, state COUNT, proto_err=0.
REQ-040 Violations: div_start in COUNT -> ignored and proto_err=1; rst at cycle 10 of a divide -> all outputs 0, no div_wb_req.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard detector: load-use and divider RAW/WAW/structural stalls,
// plus the iterative-divider issue/writeback tracker with a one-hot pending mask.
module hazard_scoreboard #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_valid,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_uses_rs1,
  input  logic        ID_uses_rs2,
  input  logic [4:0]  ID_rd,
  input  logic        ID_regwrite,
  input  logic        ID_is_div,
  input  logic [4:0]  EX_rd,
  input  logic        EX_regwrite,
  input  logic        EX_memread,
  input  logic        div_start,
  input  logic        div_wb_ack,
  output logic        stall,
  output logic        div_busy,
  output logic        div_wb_req,
  output logic [4:0]  div_wb_rd,
  output logic [31:0] pending_mask,
  output logic        proto_err
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned REG_N = 32;
  localparam int unsigned RID_W = 5;

  typedef enum logic [1:0] {IDLE, COUNT, REQ} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_N-1:0]   mask_q, mask_d;
  logic [RID_W-1:0]   wb_rd_q, wb_rd_d;
  logic               err_q, err_d;

  logic               launch;
  logic [REG_N-1:0]   mask_eff;
  logic               busy_eff, req_eff;
  logic               load_use, div_raw, div_waw, div_struct;

  // Divider tracker next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    wb_rd_d = wb_rd_q;
    err_d   = err_q;
    launch  = 1'b0;

    unique case (state_q)
      IDLE: begin
        launch = div_start;
        if (div_wb_ack) err_d = 1'b1;
      end
      COUNT: begin
        if (div_start || div_wb_ack) err_d = 1'b1;
        if (cnt_q == '0) state_d = REQ;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      REQ: begin
        if (div_wb_ack) begin
          mask_d[wb_rd_q] = 1'b0;
          state_d         = IDLE;
          launch          = div_start;
        end else if (div_start) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clearing the retired bit above happens first, so a same-register restart keeps it set
    if (launch) begin
      state_d = COUNT;
      cnt_d   = CNT_W'(DIV_CYCLES - 1);
      wb_rd_d = EX_rd;
      if (EX_rd != '0) mask_d[EX_rd] = 1'b1;
    end
    mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      wb_rd_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      wb_rd_q <= wb_rd_d;
      err_q   <= err_d;
    end
  end

  // Stall decode; while rst is high it sees the state as already cleared
  always_comb begin
    mask_eff   = rst ? '0 : mask_q;
    busy_eff   = !rst && (state_q != IDLE);
    req_eff    = !rst && (state_q == REQ);
    load_use   = EX_memread && EX_regwrite && (EX_rd != '0) &&
                 ((ID_uses_rs1 && (ID_rs1 == EX_rd)) || (ID_uses_rs2 && (ID_rs2 == EX_rd)));
    div_raw    = (ID_uses_rs1 && mask_eff[ID_rs1]) || (ID_uses_rs2 && mask_eff[ID_rs2]);
    div_waw    = ID_regwrite && (ID_rd != '0) && mask_eff[ID_rd];
    div_struct = ID_is_div && busy_eff && !(req_eff && div_wb_ack);
  end

  assign stall        = ID_valid && (load_use || div_raw || div_waw || div_struct);
  assign div_busy     = (state_q != IDLE);
  assign div_wb_req   = (state_q == REQ);
  assign div_wb_rd    = wb_rd_q;
  assign pending_mask = mask_q;
  assign proto_err    = err_q;

endmodule
